// File: rtl/adc_sample_reader_pkg.sv
// adc_sample_reader_pkg: shared FSM state type and ADC frame constants
package adc_sample_reader_pkg;
    typedef enum logic [1:0] {IDLE, QUIET, SHIFT, DONE} state_e;
    localparam int FRAME_BITS = 16;
    localparam int LEAD_ZEROS = 4;
endpackage

// File: rtl/sample_fifo.sv
// sample_fifo: first-word-fall-through FIFO with registered occupancy count
module sample_fifo #(
    parameter int WIDTH = 22,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0] count_q, count_d;
    logic do_push, do_pop;
    assign full = count_q == (AW+1)'(DEPTH);
    assign empty = count_q == '0;
    assign rd_data = mem_q[rd_ptr_q];
    always_comb begin
        do_pop = pop & ~empty;
        do_push = push & (~full | do_pop);
        mem_d = mem_q;
        if (do_push) mem_d[wr_ptr_q] = wr_data;
        wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = do_pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q <= '0;
        end else begin
            mem_q <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q <= count_d;
        end
    end
endmodule

// File: rtl/adc_sample_reader.sv
// adc_sample_reader: triggered serial ADC frame reader with tagged FWFT sample buffer
module adc_sample_reader
    import adc_sample_reader_pkg::*;
#(
    parameter int SAMPLE_W = 12,
    parameter int TAG_W = 10,
    parameter int CLK_DIV = 25,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                      fpga_clk,
    input  logic                      rst,
    input  logic                      adc_trg_n,
    input  logic [TAG_W-1:0]          rot_count,
    input  logic                      flag_clr,
    output logic                      adc_cs_n,
    output logic                      adc_sclk,
    input  logic                      adc_sdata,
    input  logic                      rd_en,
    output logic                      rd_valid,
    output logic [TAG_W+SAMPLE_W-1:0] rd_data,
    output logic                      busy,
    output logic                      ovf_flag,
    output logic                      miss_flag
);
    localparam int CW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
    localparam int BW = $clog2(FRAME_BITS);
    localparam logic [CW-1:0] CNT_MAX = CW'(CLK_DIV - 1);
    localparam logic [BW-1:0] BIT_MAX = BW'(FRAME_BITS - 1);
    localparam logic [BW-1:0] LEAD = BW'(LEAD_ZEROS);
    state_e state_q, state_d;
    logic [2:0] sync_q, sync_d;
    logic trig_q, trig_d, wrap, push, full, empty;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [BW-1:0] bit_q, bit_d;
    logic cs_n_q, cs_n_d, sclk_q, sclk_d, busy_q, busy_d;
    logic ovf_q, ovf_d, miss_q, miss_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic [SAMPLE_W-1:0] sample_q, sample_d;
    assign wrap = cnt_q == CNT_MAX;
    always_comb begin
        sync_d = {sync_q[1:0], adc_trg_n};
        trig_d = sync_q[2] & ~sync_q[1];
        state_d = state_q;
        cnt_d = wrap ? '0 : cnt_q + 1'b1;
        bit_d = bit_q;
        cs_n_d = cs_n_q;
        sclk_d = sclk_q;
        tag_d = tag_q;
        sample_d = sample_q;
        push = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (trig_q) begin
                    state_d = QUIET;
                    cs_n_d = 1'b0;
                    tag_d = rot_count;
                end
            end
            QUIET: if (wrap) begin
                state_d = SHIFT;
                sclk_d = 1'b0;
                bit_d = '0;
            end
            SHIFT: if (wrap) begin
                if (!sclk_q) begin
                    sclk_d = 1'b1;
                    if (bit_q >= LEAD) sample_d = {sample_q[SAMPLE_W-2:0], adc_sdata};
                end else if (bit_q == BIT_MAX) begin
                    state_d = DONE;
                end else begin
                    sclk_d = 1'b0;
                    bit_d = bit_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
                cs_n_d = 1'b1;
                push = 1'b1;
            end
            default: state_d = IDLE;
        endcase
        busy_d = state_d != IDLE;
        miss_d = (miss_q & ~flag_clr) | (trig_q & (state_q != IDLE));
        ovf_d = (ovf_q & ~flag_clr) | (push & full & ~rd_en);
    end
    always_ff @(posedge fpga_clk) begin
        if (rst) begin
            state_q <= IDLE;
            sync_q <= '1;
            trig_q <= 1'b0;
            cnt_q <= '0;
            bit_q <= '0;
            cs_n_q <= 1'b1;
            sclk_q <= 1'b1;
            busy_q <= 1'b0;
            tag_q <= '0;
            sample_q <= '0;
            ovf_q <= 1'b0;
            miss_q <= 1'b0;
        end else begin
            state_q <= state_d;
            sync_q <= sync_d;
            trig_q <= trig_d;
            cnt_q <= cnt_d;
            bit_q <= bit_d;
            cs_n_q <= cs_n_d;
            sclk_q <= sclk_d;
            busy_q <= busy_d;
            tag_q <= tag_d;
            sample_q <= sample_d;
            ovf_q <= ovf_d;
            miss_q <= miss_d;
        end
    end
    sample_fifo #(.WIDTH(TAG_W + SAMPLE_W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk(fpga_clk),
        .rst(rst),
        .push(push),
        .wr_data({tag_q, sample_q}),
        .pop(rd_en),
        .rd_data(rd_data),
        .full(full),
        .empty(empty)
    );
    assign adc_cs_n = cs_n_q;
    assign adc_sclk = sclk_q;
    assign busy = busy_q;
    assign ovf_flag = ovf_q;
    assign miss_flag = miss_q;
    assign rd_valid = ~empty;
endmodule
